// File: rtl/fifo_uart_tx.sv
// Drains bytes from a synchronous FIFO read port and serialises each one as an
// 8N1 UART frame, LSB first. Copes with registered read data and dropped reads.
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wr_active,
  output logic                  ren,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_WIDTH-1:0] BAUD_LAST = CNT_WIDTH'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]     BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, REQ, LOAD, START, DATA, STOP} state_t;

  state_t                state, state_n;
  logic [CNT_WIDTH-1:0]  baud_cnt, baud_cnt_n;
  logic [BIT_W-1:0]      bit_cnt, bit_cnt_n;
  logic [DATA_WIDTH-1:0] shift, shift_n;
  logic                  ren_n, tx_n;
  logic                  baud_end;

  assign baud_end = (baud_cnt == BAUD_LAST);
  assign busy     = (state != IDLE);
  assign tx_done  = (state == STOP) && baud_end;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      ren      <= 1'b0;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
    end else begin
      state    <= state_n;
      ren      <= ren_n;
      tx       <= tx_n;
      baud_cnt <= baud_cnt_n;
      bit_cnt  <= bit_cnt_n;
      shift    <= shift_n;
    end
  end

  always_comb begin
    state_n    = state;
    ren_n      = 1'b0;
    tx_n       = tx;
    baud_cnt_n = baud_end ? '0 : baud_cnt + 1'b1;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift;
    case (state)
      IDLE: begin
        baud_cnt_n = '0;
        if (!empty) begin
          state_n = REQ;
          ren_n   = 1'b1;
        end
      end
      // A write in the strobe cycle makes the FIFO drop our read; go back and retry.
      REQ: begin
        baud_cnt_n = '0;
        state_n    = wr_active ? IDLE : LOAD;
      end
      LOAD: begin
        baud_cnt_n = '0;
        bit_cnt_n  = '0;
        shift_n    = data_in;
        tx_n       = 1'b0;
        state_n    = START;
      end
      START: begin
        if (baud_end) begin
          state_n = DATA;
          tx_n    = shift[0];
        end
      end
      DATA: begin
        if (baud_end) begin
          if (bit_cnt == BIT_LAST) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
            shift_n   = {1'b0, shift[DATA_WIDTH-1:1]};
            tx_n      = shift[1];
          end
        end
      end
      STOP: begin
        if (baud_end) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

endmodule
